// File: rtl/irq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the 4-source interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned VEC_W   = 2;

    // Handshake state toward the consumer
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } state_e;

    // One-hot expansion of a source vector, used to clear the accepted pending bit
    function automatic logic [NUM_SRC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        logic [NUM_SRC-1:0] oh;
        oh    = '0;
        oh[v] = 1'b1;
        return oh;
    endfunction

endpackage : irq_ctrl_pkg

// File: rtl/priority_encoder_4to2.sv
// 4:2 priority encoder; in[3] has the highest priority, valid flags any set input.
module priority_encoder_4to2 (
    input  logic [3:0] in,
    output logic [1:0] y,
    output logic       valid
);

    // Highest set bit wins
    always_comb begin
        y     = 2'b00;
        valid = 1'b1;
        if (in[3]) begin
            y = 2'b11;
        end else if (in[2]) begin
            y = 2'b10;
        end else if (in[1]) begin
            y = 2'b01;
        end else if (in[0]) begin
            y = 2'b00;
        end else begin
            valid = 1'b0;
        end
    end

endmodule : priority_encoder_4to2

// File: rtl/irq_ctrl_4ch.sv
// 4-source interrupt controller: edge detect, sticky pending, mask, priority
// selection and a request/ack/eoi handshake toward a single consumer.
// Optional service timeout is compiled in with `define IRQ_TIMEOUT_EN.
module irq_ctrl_4ch
    import irq_ctrl_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] MASK_RST   = 4'b0000,
    parameter int unsigned        TMO_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_out,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [VEC_W-1:0]   active_vec,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask_q,
    output logic               tmo_err
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [NUM_SRC-1:0] r_irq_in_d;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_pm;
    logic [VEC_W-1:0]   w_y;
    logic               w_valid;
    logic [VEC_W-1:0]   r_irq_vec;
    logic [VEC_W-1:0]   w_irq_vec_nxt;
    logic [VEC_W-1:0]   r_active_vec;
    logic [VEC_W-1:0]   w_active_vec_nxt;
    logic               r_irq_out;
    logic               r_busy;
    logic               r_tmo_err;
    logic               w_tmo_err_nxt;
    logic               w_tmo_hit;

    assign w_rise = irq_in & ~r_irq_in_d;
    assign w_pm   = r_pending & ~r_mask;

    // Masked pending vector selects the presented source
    priority_encoder_4to2 u_penc (
        .in    (w_pm),
        .y     (w_y),
        .valid (w_valid)
    );

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    logic [7:0] r_tmo_cnt;

    // Service-cycle counter: held at zero outside SERV, so it starts at zero on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state != SERV) begin
            r_tmo_cnt <= 8'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // Limit reached during the TMO_CYCLES-th service cycle
    assign w_tmo_hit = (r_state == SERV) && (r_tmo_cnt == TMO_LAST);
`else
    // The limit has no effect without the timeout counter
    localparam int unsigned TMO_CYCLES_UNUSED = TMO_CYCLES;

    assign w_tmo_hit = 1'b0;
`endif

    // Next-state, vector and clear decode for the consumer handshake
    always_comb begin
        w_state_nxt      = r_state;
        w_irq_vec_nxt    = r_irq_vec;
        w_active_vec_nxt = r_active_vec;
        w_clr            = '0;
        w_tmo_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt   = REQ;
                    w_irq_vec_nxt = w_y;
                end
            end
            REQ: begin
                // Ack accepts the vector presented in this cycle, even if it was just masked
                if (irq_ack) begin
                    w_state_nxt      = SERV;
                    w_active_vec_nxt = r_irq_vec;
                    w_clr            = vec_onehot(r_irq_vec);
                end else if (w_valid) begin
                    w_irq_vec_nxt = w_y;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SERV: begin
                if (eoi) begin
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = IDLE;
                    w_tmo_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, handshake outputs and vectors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_irq_vec    <= '0;
            r_active_vec <= '0;
            r_irq_out    <= 1'b0;
            r_busy       <= 1'b0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_irq_vec    <= w_irq_vec_nxt;
            r_active_vec <= w_active_vec_nxt;
            r_irq_out    <= (w_state_nxt == REQ);
            r_busy       <= (w_state_nxt == SERV);
            r_tmo_err    <= w_tmo_err_nxt;
        end
    end

    // Edge history, sticky pending (a new rise beats a same-cycle clear) and mask
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_in_d <= '0;
            r_pending  <= '0;
            r_mask     <= MASK_RST;
        end else begin
            r_irq_in_d <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign irq_out    = r_irq_out;
    assign irq_vec    = r_irq_vec;
    assign active_vec = r_active_vec;
    assign busy       = r_busy;
    assign pending    = r_pending;
    assign mask_q     = r_mask;
    assign tmo_err    = r_tmo_err;

endmodule : irq_ctrl_4ch

// File: tb/tb_irq_ctrl_4ch.sv
// Directed self-checking bench for irq_ctrl_4ch (timeout limit overridden to 8).
module tb_irq_ctrl_4ch;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       irq_ack;
    logic       eoi;
    logic       irq_out;
    logic [1:0] irq_vec;
    logic [1:0] active_vec;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] mask_q;
    logic       tmo_err;

    int n_pass = 0;
    int n_chk  = 0;

    irq_ctrl_4ch #(
        .MASK_RST   (4'b0000),
        .TMO_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_out    (irq_out),
        .irq_vec    (irq_vec),
        .active_vec (active_vec),
        .busy       (busy),
        .pending    (pending),
        .mask_q     (mask_q),
        .tmo_err    (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; irq_in = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0;
        irq_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        chk("rst_pending", pending, 4'h0);
        chk("rst_mask", mask_q, 4'h0);
        chk("rst_irq_out", {3'b0, irq_out}, 4'h0);
        chk("rst_irq_vec", {2'b0, irq_vec}, 4'h0);
        chk("rst_active", {2'b0, active_vec}, 4'h0);
        chk("rst_busy", {3'b0, busy}, 4'h0);
        chk("rst_tmo", {3'b0, tmo_err}, 4'h0);
        rst = 1'b0;

        // Single event on source 0
        irq_in = 4'b0001;
        tick();
        chk("t1_pending", pending, 4'b0001);
        chk("t1_irq_out_early", {3'b0, irq_out}, 4'h0);
        irq_in = 4'b0000;
        tick();
        chk("t1_irq_out", {3'b0, irq_out}, 4'h1);
        chk("t1_irq_vec", {2'b0, irq_vec}, 4'h0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_ack_pending", pending, 4'h0);
        chk("t1_ack_busy", {3'b0, busy}, 4'h1);
        chk("t1_ack_irq_out", {3'b0, irq_out}, 4'h0);
        chk("t1_active", {2'b0, active_vec}, 4'h0);
        tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t1_eoi_busy", {3'b0, busy}, 4'h0);
        chk("t1_eoi_irq_out", {3'b0, irq_out}, 4'h0);
        tick();
        chk("t1_idle_irq_out", {3'b0, irq_out}, 4'h0);

        // Simultaneous sources 1 and 2
        irq_in = 4'b0110;
        tick();
        irq_in = 4'b0000;
        chk("t2_pending", pending, 4'b0110);
        tick();
        chk("t2_irq_out", {3'b0, irq_out}, 4'h1);
        chk("t2_irq_vec", {2'b0, irq_vec}, 4'h2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t2_ack_pending", pending, 4'b0010);
        chk("t2_active", {2'b0, active_vec}, 4'h2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t2_eoi_irq_out", {3'b0, irq_out}, 4'h0);
        tick();
        chk("t2_rearm_irq_out", {3'b0, irq_out}, 4'h1);
        chk("t2_rearm_irq_vec", {2'b0, irq_vec}, 4'h1);

        // Preemption by source 3 while presenting source 1
        irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        chk("t3_pending", pending, 4'b1010);
        chk("t3_vec_before", {2'b0, irq_vec}, 4'h1);
        tick();
        chk("t3_vec_preempt", {2'b0, irq_vec}, 4'h3);
        chk("t3_irq_out", {3'b0, irq_out}, 4'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t3_ack_pending", pending, 4'b0010);
        chk("t3_active", {2'b0, active_vec}, 4'h3);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("t3_rearm_vec", {2'b0, irq_vec}, 4'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t3_drain_pending", pending, 4'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;

        // Mask holds a request off without clearing it
        mask_we = 1'b1; mask_wdata = 4'b1000;
        tick();
        mask_we = 1'b0;
        chk("t4_mask_q", mask_q, 4'b1000);
        irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        chk("t4_pending", pending, 4'b1000);
        tick(); tick();
        chk("t4_masked_irq_out", {3'b0, irq_out}, 4'h0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t4_stray_ack_busy", {3'b0, busy}, 4'h0);
        chk("t4_stray_ack_pending", pending, 4'b1000);
        mask_we = 1'b1; mask_wdata = 4'b0000;
        tick();
        mask_we = 1'b0;
        chk("t4_unmask_early", {3'b0, irq_out}, 4'h0);
        tick();
        chk("t4_unmask_irq_out", {3'b0, irq_out}, 4'h1);
        chk("t4_unmask_vec", {2'b0, irq_vec}, 4'h3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;

        // Level held high produces a single event
        irq_in = 4'b0100;
        tick();
        chk("t5_pending", pending, 4'b0100);
        tick();
        chk("t5_vec", {2'b0, irq_vec}, 4'h2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t5_ack_pending", pending, 4'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        repeat (6) tick();
        chk("t5_hold_pending", pending, 4'h0);
        chk("t5_hold_irq_out", {3'b0, irq_out}, 4'h0);
        irq_in = 4'b0000;
        tick();

        // New rise of the acked source in the ack cycle keeps it pending
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        tick();
        chk("t5_req_again", {3'b0, irq_out}, 4'h1);
        irq_ack = 1'b1; irq_in = 4'b0100;
        tick();
        irq_ack = 1'b0;
        chk("t5_collide_pending", pending, 4'b0100);
        chk("t5_collide_busy", {3'b0, busy}, 4'h1);
        chk("t5_collide_active", {2'b0, active_vec}, 4'h2);

        // Reset during SERV discards everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_pending", pending, 4'h0);
        chk("t5_rst_busy", {3'b0, busy}, 4'h0);
        chk("t5_rst_irq_out", {3'b0, irq_out}, 4'h0);
        chk("t5_rst_active", {2'b0, active_vec}, 4'h0);
        chk("t5_rst_vec", {2'b0, irq_vec}, 4'h0);
        tick();
        chk("t5_post_rst_event", pending, 4'b0100);
        irq_in = 4'b0000;
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t6_serv_busy", {3'b0, busy}, 4'h1);

        // Service without eoi: timeout at service cycle 8 when compiled in
        repeat (7) tick();
        chk("t6_cycle8_busy", {3'b0, busy}, 4'h1);
        chk("t6_cycle8_tmo", {3'b0, tmo_err}, 4'h0);
        tick();
`ifdef IRQ_TIMEOUT_EN
        chk("t6_tmo_pulse", {3'b0, tmo_err}, 4'h1);
        chk("t6_tmo_busy", {3'b0, busy}, 4'h0);
        tick();
        chk("t6_tmo_single", {3'b0, tmo_err}, 4'h0);
`else
        chk("t6_no_tmo", {3'b0, tmo_err}, 4'h0);
        chk("t6_still_busy", {3'b0, busy}, 4'h1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t6_eoi_busy", {3'b0, busy}, 4'h0);
`endif

        // eoi on service cycle 8 exits normally
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (7) tick();
        chk("t7_cycle8_busy", {3'b0, busy}, 4'h1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t7_eoi_busy", {3'b0, busy}, 4'h0);
        chk("t7_eoi_no_tmo", {3'b0, tmo_err}, 4'h0);
        tick();
        chk("t7_after_no_tmo", {3'b0, tmo_err}, 4'h0);
        chk("t7_idle_irq_out", {3'b0, irq_out}, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_irq_ctrl_4ch

// File: doc/irq_ctrl_4ch.md
Name: irq_ctrl_4ch

Overview:
- 4-source interrupt controller built around the existing 4:2 priority encoder.
- Turns raw request lines into sticky pending bits with edge detection.
- Applies a per-source mask and feeds the masked pending vector to the encoder.
- Runs a request/acknowledge/end-of-interrupt handshake toward a single consumer (CPU or sequencer), presenting the highest-priority vector (in[3] highest).

Parameters:
- MASK_RST, 4'b0000, reset value of the mask register (1 = source masked).
- TMO_CYCLES, 16, service-timeout limit in cycles; used only when IRQ_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- irq_in  input  4  raw level requests; a 0->1 transition is one event
- mask_we  input  1  mask write strobe
- mask_wdata  input  4  new mask value
- irq_ack  input  1  consumer accepts the presented vector
- eoi  input  1  consumer finished servicing
- irq_out  output  1  interrupt request to consumer
- irq_vec  output  2  vector of the presented request
- active_vec  output  2  vector currently in service
- busy  output  1  high while in SERV
- pending  output  4  sticky pending register
- mask_q  output  4  current mask
- tmo_err  output  1  timeout pulse (feature only)

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=IDLE, irq_in_d=0, pending=0, mask_q=MASK_RST, irq_out=0, irq_vec=2'b00, active_vec=2'b00, busy=0, tmo_err=0.
- A reset asserted mid-REQ or mid-SERV discards all pending and in-service state.
- Edge detect: rise = irq_in & ~irq_in_d, with irq_in_d registered every cycle. A line already high when reset is released produces one event on the first cycle.
- Pending: pending <= (pending & ~clr) | rise. clr is the one-hot of irq_vec on an accepted ack. If rise and clr hit the same bit in the same cycle, set wins.
- A line held high produces exactly one event. It must fall and rise again to re-pend.
- Mask: mask_q <= mask_wdata when mask_we is high; it takes effect on the following cycle. Masking never clears pending.
- Masked pending pm = pending & ~mask_q drives the encoder. Encoder outputs are y[1:0] and valid.
- FSM states: IDLE=2'b00, REQ=2'b01, SERV=2'b10.
  - IDLE: if valid, go to REQ and set irq_vec<=y.
  - REQ: irq_out=1, decoded from the state register.
    - irq_vec re-latches y every cycle while valid, so a higher-priority arrival preempts before ack.
    - If valid drops (masked or cleared), return to IDLE with irq_out=0 next cycle.
    - On irq_ack: go to SERV, active_vec<=irq_vec, clear pending[irq_vec], and use the irq_vec value of the ack cycle.
  - SERV: busy=1, irq_out=0. On eoi, go to IDLE. Further pending requests wait.
  - irq_ack outside REQ and eoi outside SERV are ignored.
- Latency:
  - irq_in rises before edge k -> pending set after edge k.
  - irq_out=1 after edge k+1.
  - After eoi at edge m, a still-pending request re-asserts irq_out after edge m+1.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- With it defined:
  - An 8-bit counter clears on SERV entry and increments every SERV cycle.
  - If the counter reaches TMO_CYCLES without eoi, force IDLE and pulse tmo_err high for exactly 1 cycle.
  - eoi in the same cycle as the timeout wins: normal exit, no tmo_err.
- Without it: no counter exists, tmo_err is tied 0, and SERV waits indefinitely.

Decomposition:
- Package irq_ctrl_pkg holds NUM_SRC=4, VEC_W=2, and the state encoding constants IDLE, REQ and SERV.
- One sub-module: priority_encoder_4to2, instantiated unchanged on pm to produce y and valid.
- Edge detect, pending, mask and FSM stay in irq_ctrl_4ch.

Test Plan:
- Single event: rst, then pulse irq_in=0001. Expect pending=0001, and irq_out=1 with irq_vec=00 two cycles after the rise. Then ack -> pending=0000, busy=1, active_vec=00. Then eoi -> IDLE with irq_out=0.
- Simultaneous: irq_in=0110. Expect irq_vec=10. After ack, pending=0010. After eoi, irq_out re-asserts with irq_vec=01.
- Preemption: in REQ with irq_vec=01, raise irq_in[3]. Expect irq_vec=11 two cycles later. Ack then clears pending[3] only; pending[1] stays set.
- Mask: write mask=1000, then irq_in=1000. Expect pending=1000 and irq_out stays 0. Write mask=0000 -> irq_out=1, irq_vec=11 two cycles after the write.
- Level hold and collisions: hold irq_in=0100 for 10 cycles. Expect one event; after ack, pending stays 0. Rise the same source in the ack cycle -> pending bit remains 1. Assert rst during SERV -> all outputs return to reset values next cycle.
- With IRQ_TIMEOUT_EN and TMO_CYCLES=8: ack and never eoi. Expect a tmo_err single-cycle pulse at SERV cycle 8, state IDLE, busy=0. Repeat with eoi on cycle 8 -> no tmo_err.
